// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Stalls IF/ID/EX for 33 cycles and pulses done with quotient (LO) and remainder (HI).
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic        signedE,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall_divE,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, abs_b;
  logic        sign_q, sign_r, b_zero;

  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] step_rem, step_quo;

  // One restoring step: shift {rem,quo} left, subtract |b| when it fits.
  always_comb begin
    shifted  = {rem, quo[31]};
    diff     = shifted - {1'b0, abs_b};
    ge       = (shifted >= {1'b0, abs_b});
    step_rem = ge ? diff[31:0] : shifted[31:0];
    step_quo = {quo[30:0], ge};
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (startE) state_nx = RUN;
      RUN:     if (cnt == 6'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (cancel) state_nx = IDLE;
  end

  assign busy       = (state == RUN);
  assign done       = (state == DONE) && !cancel && !rst;
  assign stall_divE = !rst && !cancel && (((state == IDLE) && startE) || (state == RUN));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 6'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      abs_b     <= 32'd0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      b_zero    <= 1'b0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
    end else if (!cancel) begin
      case (state)
        IDLE: if (startE) begin
          rem    <= 32'd0;
          quo    <= (signedE && a[31]) ? -a : a;
          abs_b  <= (signedE && b[31]) ? -b : b;
          sign_q <= (a[31] ^ b[31]) & signedE;
          sign_r <= a[31] & signedE;
          b_zero <= (b == 32'd0);
          cnt    <= 6'd0;
        end
        RUN: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            // Divide by zero yields all ones; the remainder fix-up restores a exactly.
            quotient  <= b_zero ? 32'hFFFF_FFFF : (sign_q ? -step_quo : step_quo);
            remainder <= sign_r ? -step_rem : step_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: table-driven divides plus cancel/reset/back-to-back sequences.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst, startE, signedE, cancel;
  logic [31:0] a, b;
  logic        stall_divE, busy, done;
  logic [31:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_div dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .stall_divE (stall_divE),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too, mid-cycle.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eq, input logic [31:0] er);
    int bad_stall, bad_done;
    bad_stall = 0;
    bad_done  = 0;
    startE = 1'b1; signedE = sgn; a = av; b = bv;
    #1;
    check({name, " stall@T"}, {31'd0, stall_divE}, 32'd1);
    @(negedge clk);
    startE = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
    // Cycles T+1..T+32: stalled, no done.
    for (int i = 1; i <= 32; i++) begin
      if (stall_divE !== 1'b1 || busy !== 1'b1) bad_stall++;
      if (done !== 1'b0) bad_done++;
      @(negedge clk);
    end
    check({name, " stall cycles bad"}, bad_stall, 0);
    check({name, " early done"},       bad_done,  0);
    check({name, " done@T+33"},  {31'd0, done},       32'd1);
    check({name, " stall@T+33"}, {31'd0, stall_divE}, 32'd0);
    check({name, " quotient"},   quotient,  eq);
    check({name, " remainder"},  remainder, er);
  endtask

  initial begin
    vecs[0] = '{"udiv 100/7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"sdiv -7/2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{"udiv by 0",     1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    vecs[3] = '{"sdiv by 0",     1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    vecs[4] = '{"sdiv ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[5] = '{"sdiv 7/-2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[6] = '{"sdiv -7/-2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[7] = '{"udiv max/1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[8] = '{"udiv 5/10",     1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
    vecs[9] = '{"sdiv -8 by 0",  1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8};

    rst = 1'b1; startE = 1'b1; signedE = 1'b0; cancel = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    check("reset stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    check("reset busy",      {31'd0, busy}, 32'd0);
    check("reset done",      {31'd0, done}, 32'd0);
    check("reset quotient",  quotient,  32'd0);
    check("reset remainder", remainder, 32'd0);
    rst = 1'b0; startE = 1'b0;
    @(negedge clk);

    // Consecutive vectors start in the cycle right after each DONE (back-to-back).
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      @(negedge clk);
    end
    check("idle done after run", {31'd0, done}, 32'd0);

    // Cancel together with start in IDLE: cancel wins.
    startE = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd5;
    #1;
    check("cancel+start stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    startE = 1'b0; cancel = 1'b0;
    check("cancel+start busy", {31'd0, busy}, 32'd0);

    // Cancel at RUN step 10: outputs keep the previous result (-8 by 0).
    startE = 1'b1; signedE = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    startE = 1'b0;
    repeat (10) @(negedge clk);
    check("run before cancel", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    #1;
    check("cancel stall", {31'd0, stall_divE}, 32'd0);
    check("cancel done",  {31'd0, done},       32'd0);
    @(negedge clk);
    cancel = 1'b0;
    check("post-cancel busy",      {31'd0, busy}, 32'd0);
    check("post-cancel quotient",  quotient,  32'hFFFF_FFFF);
    check("post-cancel remainder", remainder, 32'hFFFF_FFF8);
    run_div("udiv 9/3 after cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    @(negedge clk);

    // Reset mid-RUN: abort, clear results, never pulse done.
    startE = 1'b1; signedE = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    startE = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; startE = 1'b1;
    #1;
    check("rst mid-run stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    rst = 1'b0; startE = 1'b0;
    check("post-rst busy",      {31'd0, busy},       32'd0);
    check("post-rst stall",     {31'd0, stall_divE}, 32'd0);
    check("post-rst quotient",  quotient,  32'd0);
    check("post-rst remainder", remainder, 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
        if (done) seen_done++;
        @(negedge clk);
      end
      check("no done after rst", seen_done, 0);
    end
    run_div("udiv 100/7 after rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
